// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared integer-register-file defaults for the RISC-V datapath blocks.
//   RV_XLEN     : default data width in bits
//   RV_NREGS    : default architectural register count
//   RV_REG_ZERO : index of the hard-wired zero register (x0)
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int RV_XLEN     = 32;
    localparam int RV_NREGS    = 32;
    localparam int RV_REG_ZERO = 0;

endpackage : riscv_pkg

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// One busy bit per architectural register, marking a result that is still
// outstanding. An issue sets the destination's bit; a write with its clear
// flag releases the written register. The lookup ports see same-cycle
// clears, so a consumer can proceed in the cycle the producer writes back.
// Same-cycle sets are not visible until the next edge.
//
// Ports:
//   clk       : clock, state changes on rising edge
//   rst       : asynchronous active-high reset, drops every busy bit
//   set_valid : mark set_addr busy at the next edge
//   set_addr  : register being marked busy (AW bits)
//   clr_en    : per write port, clear the busy bit of clr_addr slice j
//   clr_addr  : per write port address, NWR*AW bits
//   rd_addr   : per lookup port address, NRD*AW bits
//   rd_busy   : per lookup port busy flag (with clear bypass)
// ---------------------------------------------------------------------------
module regfile_scoreboard
    import riscv_pkg::*;
#(
    parameter int NREGS = RV_NREGS,
    parameter int NWR   = 2,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_valid,
    input  logic [AW-1:0]     set_addr,
    input  logic [NWR-1:0]    clr_en,
    input  logic [NWR*AW-1:0] clr_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_clr_mask;
    logic [NREGS-1:0] w_set_mask;
    logic [NREGS-1:0] w_busy_nxt;

    always_comb begin
        w_clr_mask = '0;
        for (int j = 0; j < NWR; j++) begin
            if (clr_en[j]) begin
                w_clr_mask[clr_addr[j*AW +: AW]] = 1'b1;
            end
        end
    end

    always_comb begin
        w_set_mask = '0;
        if (set_valid) begin
            w_set_mask[set_addr] = 1'b1;
        end
    end

    // Set is applied after clear so a new producer issued in the same cycle
    // as the old one's writeback keeps the register busy. x0 is never busy.
    always_comb begin
        w_busy_nxt = (r_busy & ~w_clr_mask) | w_set_mask;
        w_busy_nxt[RV_REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_lookup
            logic [AW-1:0] w_ra;
            assign w_ra        = rd_addr[gi*AW +: AW];
            assign rd_busy[gi] = r_busy[w_ra] & ~w_clr_mask[w_ra];
        end
    endgenerate

endmodule : regfile_scoreboard

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
// Multi-ported integer register file with same-cycle write bypass and a
// busy-bit scoreboard for outstanding results. x0 reads as zero, ignores
// writes and is never busy. When several write ports hit one address, the
// highest-index (youngest) port wins, both for commit and for bypass.
//
// Ports:
//   clk       : clock, state changes on rising edge
//   rst       : asynchronous active-high reset, clears registers and busy
//   rs        : read addresses, port i in slice i (NRD*AW bits)
//   rdata     : combinational read data, port i in slice i (NRD*XLEN bits)
//   rbusy     : busy flag of each read address (same-cycle clears applied)
//   we        : write enables (NWR bits)
//   wa        : write addresses (NWR*AW bits)
//   wd        : write data (NWR*XLEN bits)
//   wclr      : on an enabled write, also clear the busy bit of wa[j]
//   iss_valid : an instruction issues with destination iss_rd
//   iss_rd    : destination register to mark busy
// ---------------------------------------------------------------------------
module regfile_mp
    import riscv_pkg::*;
#(
    parameter int XLEN  = RV_XLEN,
    parameter int NREGS = RV_NREGS,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rs,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   wa,
    input  logic [NWR*XLEN-1:0] wd,
    input  logic [NWR-1:0]      wclr,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd
);

    localparam logic [AW-1:0] ZERO_IDX = AW'(RV_REG_ZERO);

    logic [XLEN-1:0] r_regs [NREGS];
    logic [NWR-1:0]  w_clr_en;

    // Later loop iterations override earlier ones, so the highest-index
    // port's data is what lands on a colliding address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NREGS; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (we[j] && (wa[j*AW +: AW] != ZERO_IDX)) begin
                    r_regs[wa[j*AW +: AW]] <= wd[j*XLEN +: XLEN];
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]   w_ra;
            logic [XLEN-1:0] w_rd;

            assign w_ra = rs[gi*AW +: AW];

            // Bypass scan runs low to high so the youngest matching write
            // is the one returned.
            always_comb begin
                w_rd = r_regs[w_ra];
                for (int j = 0; j < NWR; j++) begin
                    if (we[j] && (wa[j*AW +: AW] == w_ra)) begin
                        w_rd = wd[j*XLEN +: XLEN];
                    end
                end
                if (w_ra == ZERO_IDX) begin
                    w_rd = '0;
                end
            end

            assign rdata[gi*XLEN +: XLEN] = w_rd;
        end
    endgenerate

    assign w_clr_en = we & wclr;

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .NRD   (NRD)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_valid (iss_valid),
        .set_addr  (iss_rd),
        .clr_en    (w_clr_en),
        .clr_addr  (wa),
        .rd_addr   (rs),
        .rd_busy   (rbusy)
    );

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = $clog2(NREGS);

    logic                clk = 1'b0;
    logic                rst;
    logic [NRD*AW-1:0]   rs;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   wa;
    logic [NWR*XLEN-1:0] wd;
    logic [NWR-1:0]      wclr;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;

    regfile_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rs        (rs),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .wclr      (wclr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd)
    );

    always #5 clk = ~clk;

    // Reference model: architectural contents and outstanding-result set.
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NREGS; k++) begin
            m_regs[k] = '0;
            m_busy[k] = 1'b0;
        end
    endfunction

    // Value a reader must see now: youngest same-cycle write, else stored.
    function automatic logic [XLEN-1:0] exp_rd(input int a);
        logic [XLEN-1:0] v;
        if (a == 0) return '0;
        v = m_regs[a];
        for (int j = 0; j < NWR; j++)
            if (we[j] && int'(wa[j*AW +: AW]) == a) v = wd[j*XLEN +: XLEN];
        return v;
    endfunction

    function automatic bit exp_busy(input int a);
        for (int j = 0; j < NWR; j++)
            if (we[j] && wclr[j] && int'(wa[j*AW +: AW]) == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic idle();
        we = '0; wa = '0; wd = '0; wclr = '0; iss_valid = 1'b0; iss_rd = '0;
    endtask

    task automatic check_all();
        int a;
        for (int i = 0; i < NRD; i++) begin
            a = int'(rs[i*AW +: AW]);
            chk($sformatf("rdata[%0d] x%0d", i, a), 64'(rdata[i*XLEN +: XLEN]), 64'(exp_rd(a)));
            chk($sformatf("rbusy[%0d] x%0d", i, a), 64'(rbusy[i]), 64'(exp_busy(a)));
        end
    endtask

    // Advance one edge; model commits the inputs present at that edge.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            for (int j = 0; j < NWR; j++)
                if (we[j] && wa[j*AW +: AW] != 0) m_regs[wa[j*AW +: AW]] = wd[j*XLEN +: XLEN];
            for (int j = 0; j < NWR; j++)
                if (we[j] && wclr[j]) m_busy[wa[j*AW +: AW]] = 1'b0;
            if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rs = '0;
        model_reset();
        tick();
        // Values during reset
        for (int a = 0; a < NREGS; a += 7) begin
            rs[0 +: AW] = AW'(a); rs[AW +: AW] = AW'(NREGS - 1 - a);
            #1;
            chk("rst_rdata0", 64'(rdata[0 +: XLEN]), 64'h0);
            chk("rst_rbusy", 64'(rbusy), 64'h0);
        end
        tick();
        rst = 1'b0;
        // All addresses on all ports after reset
        for (int a = 0; a < NREGS; a++) begin
            rs[0 +: AW] = AW'(a); rs[AW +: AW] = AW'(NREGS - 1 - a);
            #1;
            check_all();
        end

        // Bypass then commit
        idle();
        we[0] = 1'b1; wa[0 +: AW] = 5; wd[0 +: XLEN] = 32'hDEADBEEF; rs[0 +: AW] = 5;
        #1;
        chk("bypass_x5", 64'(rdata[0 +: XLEN]), 64'hDEADBEEF);
        tick();
        idle();
        #1;
        chk("commit_x5", 64'(rdata[0 +: XLEN]), 64'hDEADBEEF);

        // Colliding writes, then write to x0
        we = 2'b11; wa[0 +: AW] = 7; wa[AW +: AW] = 7; wd[0 +: XLEN] = 32'h11; wd[XLEN +: XLEN] = 32'h22;
        rs[AW +: AW] = 7;
        #1;
        chk("bypass_collide", 64'(rdata[XLEN +: XLEN]), 64'h22);
        tick();
        idle();
        we[0] = 1'b1; wa[0 +: AW] = 0; wd[0 +: XLEN] = 32'hFFFF; rs[0 +: AW] = 0;
        #1;
        chk("x0_bypass", 64'(rdata[0 +: XLEN]), 64'h0);
        tick();
        idle();
        rs[0 +: AW] = 7; rs[AW +: AW] = 0;
        #1;
        chk("collide_x7", 64'(rdata[0 +: XLEN]), 64'h22);
        chk("x0_after", 64'(rdata[XLEN +: XLEN]), 64'h0);

        // Issue, busy, clear bypass
        iss_valid = 1'b1; iss_rd = 9; rs[0 +: AW] = 9;
        #1;
        chk("no_set_bypass", 64'(rbusy[0]), 64'h0);
        tick();
        idle();
        #1;
        chk("busy_x9", 64'(rbusy[0]), 64'h1);
        we[0] = 1'b1; wclr[0] = 1'b1; wa[0 +: AW] = 9; wd[0 +: XLEN] = 32'h99;
        #1;
        chk("clr_bypass", 64'(rbusy[0]), 64'h0);
        tick();
        idle();
        #1;
        chk("clr_after", 64'(rbusy[0]), 64'h0);

        // Set wins over same-cycle clear
        iss_valid = 1'b1; iss_rd = 9;
        we[0] = 1'b1; wclr[0] = 1'b1; wa[0 +: AW] = 9; wd[0 +: XLEN] = 32'hABC;
        tick();
        idle();
        #1;
        chk("set_wins", 64'(rbusy[0]), 64'h1);
        chk("set_wins_data", 64'(rdata[0 +: XLEN]), 64'hABC);

        // Async reset mid-stream
        iss_valid = 1'b1; iss_rd = 3;
        tick();
        idle();
        we[0] = 1'b1; wa[0 +: AW] = 3; wd[0 +: XLEN] = 32'h5;
        tick();
        idle();
        rs[0 +: AW] = 3; rs[AW +: AW] = 9;
        #1;
        chk("pre_rst_x3", 64'(rdata[0 +: XLEN]), 64'h5);
        chk("pre_rst_busy", 64'(rbusy), 64'h3);
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_x3", 64'(rdata[0 +: XLEN]), 64'h0);
        chk("rst_busy", 64'(rbusy), 64'h0);
        // Write and issue during reset are dropped
        we[0] = 1'b1; wa[0 +: AW] = 4; wd[0 +: XLEN] = 32'h77; iss_valid = 1'b1; iss_rd = 4;
        tick();
        rst = 1'b0;
        idle();
        rs[0 +: AW] = 4;
        #1;
        chk("rst_drop_data", 64'(rdata[0 +: XLEN]), 64'h0);
        chk("rst_drop_busy", 64'(rbusy[0]), 64'h0);
        check_all();

        // Randomized traffic, addresses biased to a small set for collisions
        for (int n = 0; n < 400; n++) begin
            for (int j = 0; j < NWR; j++) begin
                we[j]               = ($urandom_range(0, 2) != 0);
                wclr[j]             = $urandom_range(0, 1);
                wa[j*AW +: AW]      = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 5));
                wd[j*XLEN +: XLEN]  = $urandom;
            end
            for (int i = 0; i < NRD; i++)
                rs[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 5));
            iss_valid = $urandom_range(0, 1);
            iss_rd    = AW'($urandom_range(0, 5));
            #1;
            check_all();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_regfile_mp
